intra_block_fetch: RTL and testbench

- Upstream feeder for intraloop: takes one block request as a packed {row, col} mbnumber plus a size select and reads the block's pixels and its intra-prediction neighbours from frame memory.
- Emits all of it as a tagged 32-bit word stream with valid/ready handshake.
- Serves either a 4x4 luma block or an 8x8 chroma block, for one intraloop instance; encoder_intra instantiates one per engine.

---
 rtl/intra_block_fetch_if.sv | 29 ++
 rtl/intra_block_fetch.sv | 188 ++++++++++++++++++
 tb/tb_intra_block_fetch.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/intra_block_fetch_if.sv
// Request, frame-memory and output-stream signals of intra_block_fetch.
// The fetcher takes the slave side; the requester/consumer side is the master.
interface intra_block_fetch_if #(
  parameter int ADDR_W = 18
) ();
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_mbnumber;
  logic              req_size8;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic [1:0]        out_kind;
  logic              out_last;
  logic              err;

  modport slave (
    input  req_valid, req_mbnumber, req_size8, mem_rdata, out_ready,
    output req_ready, mem_rd_en, mem_addr, out_valid, out_data, out_kind, out_last, err
  );

  modport master (
    output req_valid, req_mbnumber, req_size8, mem_rdata, out_ready,
    input  req_ready, mem_rd_en, mem_addr, out_valid, out_data, out_kind, out_last, err
  );
endinterface

// File: rtl/intra_block_fetch.sv
// Fetches one 4x4/8x8 block plus its top, top-left and left neighbours from
// frame memory and emits them as a tagged 32-bit valid/ready word stream.
module intra_block_fetch #(
  parameter int FRAME_W   = 1280,
  parameter int FRAME_H   = 720,
  parameter int ADDR_W    = 18,
  parameter int BASE_ADDR = 0
) (
  input  logic               clk,
  input  logic               reset,
  intra_block_fetch_if.slave bus
);
  localparam int PITCH = FRAME_W / 4;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_SEND} state_t;
  typedef enum logic [1:0] {K_BLOCK = 2'd0, K_TOP = 2'd1, K_TL = 2'd2, K_LEFT = 2'd3} kind_t;

  state_t      r_state, w_state_nxt;
  kind_t       r_kind, w_kind_nxt, w_enter_kind, w_next_kind;
  logic [15:0] r_row, r_col;
  logic        r_size8;
  logic [3:0]  r_idx, w_idx_nxt, w_idx_max;
  logic [1:0]  r_sub, w_sub_nxt;
  logic [31:0] r_data, w_data_nxt;
  logic        r_err, w_err_nxt;
  logic        w_accept, w_req_ok, w_enter, w_enter_avail;
  logic        w_top_avail, w_left_avail, w_item_end, w_last;
  logic [15:0] w_req_row, w_req_col, w_mrow, w_cw;
  logic [ADDR_W-1:0] w_addr;

  function automatic logic item_avail(kind_t k, logic top, logic left);
    case (k)
      K_TOP:   return top;
      K_TL:    return top & left;
      K_LEFT:  return left;
      default: return 1'b1;
    endcase
  endfunction

  assign w_req_row    = bus.req_mbnumber[31:16];
  assign w_req_col    = bus.req_mbnumber[15:0];
  assign w_accept     = bus.req_valid && (r_state == S_IDLE);
  assign w_top_avail  = |r_row;
  assign w_left_avail = |r_col;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_req_ok = ({16'd0, w_req_col} < 32'(FRAME_W)) &&
               ({16'd0, w_req_row} + (bus.req_size8 ? 32'd8 : 32'd4) <= 32'(FRAME_H));
    if (bus.req_size8) w_req_ok = w_req_ok && (w_req_col[2:0] == 3'd0) && (w_req_row[2:0] == 3'd0);
    else               w_req_ok = w_req_ok && (w_req_col[1:0] == 2'd0) && (w_req_row[1:0] == 2'd0);
  end

  // Words per item minus one, and the item that follows the current one.
  always_comb begin
    w_idx_max   = r_size8 ? 4'd15 : 4'd3;
    w_next_kind = K_BLOCK;
    case (r_kind)
      K_TOP:   begin w_idx_max = r_size8 ? 4'd1 : 4'd0; w_next_kind = K_TL; end
      K_TL:    begin w_idx_max = 4'd0; w_next_kind = K_LEFT; end
      K_LEFT:  w_idx_max = r_size8 ? 4'd1 : 4'd0;
      default: ;
    endcase
  end

  assign w_item_end = (r_idx == w_idx_max);
  assign w_last     = (r_kind == K_BLOCK) && w_item_end;

  // Pixel row and word column of the current read; left/top-left use column col-4.
  always_comb begin
    w_mrow = r_row;
    w_cw   = (r_col >> 2) - 16'd1;
    case (r_kind)
      K_TOP:  begin w_mrow = r_row - 16'd1; w_cw = (r_col >> 2) + {12'd0, r_idx}; end
      K_TL:   w_mrow = r_row - 16'd1;
      K_LEFT: w_mrow = r_row + {12'd0, r_idx[1:0], r_sub};
      default: begin
        w_mrow = r_row + (r_size8 ? {13'd0, r_idx[3:1]} : {12'd0, r_idx});
        w_cw   = (r_col >> 2) + (r_size8 ? {15'd0, r_idx[0]} : 16'd0);
      end
    endcase
    w_addr = ADDR_W'(32'(BASE_ADDR) + {16'd0, w_mrow} * 32'(PITCH) + {16'd0, w_cw});
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_kind_nxt    = r_kind;
    w_idx_nxt     = r_idx;
    w_sub_nxt     = r_sub;
    w_data_nxt    = r_data;
    w_err_nxt     = 1'b0;
    w_enter       = 1'b0;
    w_enter_kind  = r_kind;
    w_enter_avail = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_req_ok) begin
          w_enter       = 1'b1;
          w_enter_kind  = K_TOP;
          w_enter_avail = |w_req_row;
          w_idx_nxt     = 4'd0;
        end else if (w_accept) begin
          w_err_nxt = 1'b1;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        case (r_kind)
          K_TL:    w_data_nxt = {24'd0, bus.mem_rdata[31:24]};
          K_LEFT:  w_data_nxt[{r_sub, 3'b000} +: 8] = bus.mem_rdata[31:24];
          default: w_data_nxt = bus.mem_rdata;
        endcase
        // Each left word gathers four single-pixel reads before it is sent.
        if (r_kind == K_LEFT && r_sub != 2'd3) begin
          w_state_nxt = S_ISSUE;
          w_sub_nxt   = r_sub + 2'd1;
        end else begin
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (bus.out_ready) begin
          if (w_last) begin
            w_state_nxt = S_IDLE;
          end else if (w_item_end) begin
            w_enter       = 1'b1;
            w_enter_kind  = w_next_kind;
            w_enter_avail = item_avail(w_next_kind, w_top_avail, w_left_avail);
            w_idx_nxt     = 4'd0;
          end else begin
            w_enter       = 1'b1;
            w_enter_avail = item_avail(r_kind, w_top_avail, w_left_avail);
            w_idx_nxt     = r_idx + 4'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Unavailable neighbours skip the memory and go straight out as mid-grey.
    if (w_enter) begin
      w_kind_nxt = w_enter_kind;
      w_sub_nxt  = 2'd0;
      if (w_enter_avail) begin
        w_state_nxt = S_ISSUE;
      end else begin
        w_state_nxt = S_SEND;
        w_data_nxt  = (w_enter_kind == K_TL) ? 32'h0000_0080 : 32'h8080_8080;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_kind  <= K_BLOCK;
      r_idx   <= 4'd0;
      r_sub   <= 2'd0;
      r_data  <= 32'd0;
      r_err   <= 1'b0;
      r_row   <= 16'd0;
      r_col   <= 16'd0;
      r_size8 <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_kind  <= w_kind_nxt;
      r_idx   <= w_idx_nxt;
      r_sub   <= w_sub_nxt;
      r_data  <= w_data_nxt;
      r_err   <= w_err_nxt;
      if (w_accept && w_req_ok) begin
        r_row   <= w_req_row;
        r_col   <= w_req_col;
        r_size8 <= bus.req_size8;
      end
    end
  end

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.mem_rd_en = (r_state == S_ISSUE);
  assign bus.mem_addr  = (r_state == S_ISSUE) ? w_addr : '0;
  assign bus.out_valid = (r_state == S_SEND);
  assign bus.out_data  = r_data;
  assign bus.out_kind  = r_kind;
  assign bus.out_last  = (r_state == S_SEND) && w_last;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_intra_block_fetch.sv
// Self-checking bench for intra_block_fetch: pixel-level reference model,
// memory responder, per-cycle stream/read monitor and directed requests.
module tb_intra_block_fetch;
  localparam int FRAME_W   = 1280;
  localparam int FRAME_H   = 720;
  localparam int ADDR_W    = 18;
  localparam int BASE_ADDR = 0;
  localparam int PITCH     = FRAME_W / 4;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  kind;
    logic        last;
  } word_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  intra_block_fetch_if #(.ADDR_W(ADDR_W)) bus ();

  intra_block_fetch #(
    .FRAME_W(FRAME_W), .FRAME_H(FRAME_H), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  word_t exp_out[$];
  word_t out_log[$];
  int    exp_rd[$];
  int    rd_log[$];
  int    total = 0, bad = 0, cyc = 0;
  int    first_valid_cyc = -1, first_rd_cyc = -1, last_acc = 0, stalls_done = 0;
  logic  held = 1'b0;
  word_t prev, mon_e;
  int    mon_a;

  int t1_rd[10]  = '{962, 961, 1281, 1601, 1921, 2241, 1282, 1602, 1922, 2242};
  int t1_kind[7] = '{1, 2, 3, 0, 0, 0, 0};
  int t2_rd[4]   = '{0, 320, 640, 960};
  int t3_rd[8]   = '{3, 323, 643, 963, 1283, 1603, 1923, 2243};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'hA5C3_5A3C;
  endfunction

  function automatic int addr_of(input int r, input int c);
    return BASE_ADDR + r * PITCH + c / 4;
  endfunction

  function automatic logic [7:0] pix(input int r, input int c);
    logic [31:0] w;
    w = mem_val(32'(addr_of(r, c)));
    return w[8*(c%4) +: 8];
  endfunction

  function automatic logic [31:0] quad(input int r, input int c);
    return {pix(r, c + 3), pix(r, c + 2), pix(r, c + 1), pix(r, c)};
  endfunction

  // Expected stream and read addresses for one request, straight from the pixel rules.
  task automatic build_model(input int row, input int col, input bit s8);
    int n;
    bit ta, la;
    logic [31:0] w;
    n  = s8 ? 8 : 4;
    ta = (row != 0);
    la = (col != 0);
    exp_out.delete();
    exp_rd.delete();
    for (int j = 0; j < n / 4; j++) begin
      if (ta) begin
        w = quad(row - 1, col + 4 * j);
        exp_rd.push_back(addr_of(row - 1, col + 4 * j));
      end else w = 32'h8080_8080;
      exp_out.push_back('{w, 2'd1, 1'b0});
    end
    if (ta && la) begin
      w = {24'd0, pix(row - 1, col - 1)};
      exp_rd.push_back(addr_of(row - 1, col - 1));
    end else w = 32'h0000_0080;
    exp_out.push_back('{w, 2'd2, 1'b0});
    for (int j = 0; j < n / 4; j++) begin
      w = 32'h8080_8080;
      for (int i = 0; i < 4; i++) begin
        if (la) begin
          w[8*i +: 8] = pix(row + 4 * j + i, col - 1);
          exp_rd.push_back(addr_of(row + 4 * j + i, col - 1));
        end
      end
      exp_out.push_back('{w, 2'd3, 1'b0});
    end
    for (int r = 0; r < n; r++) begin
      for (int j = 0; j < n / 4; j++) begin
        exp_out.push_back('{quad(row + r, col + 4 * j), 2'd0, (r == n - 1) && (j == n / 4 - 1)});
        exp_rd.push_back(addr_of(row + r, col + 4 * j));
      end
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Frame memory: data appears the cycle after the read strobe.
  always @(posedge clk)
    bus.mem_rdata <= bus.mem_rd_en ? mem_val(32'(bus.mem_addr)) : 32'hDEAD_BEEF;

  always @(negedge clk) begin
    if (reset) begin
      held = 1'b0;
    end else begin
      if (bus.mem_rd_en) begin
        rd_log.push_back(int'(bus.mem_addr));
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        if (exp_rd.size() == 0) check("rd_unexpected", 32'(bus.mem_rd_en), 32'd0);
        else begin
          mon_a = exp_rd.pop_front();
          check("rd_addr", 32'(bus.mem_addr), 32'(mon_a));
        end
      end
      if (bus.out_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        check("rd_during_send", 32'(bus.mem_rd_en), 32'd0);
        if (held) begin
          check("stall_data", bus.out_data, prev.data);
          check("stall_kind", 32'(bus.out_kind), 32'(prev.kind));
          check("stall_last", 32'(bus.out_last), 32'(prev.last));
        end
        if (bus.out_ready) begin
          out_log.push_back('{bus.out_data, bus.out_kind, bus.out_last});
          if (exp_out.size() == 0) check("out_unexpected", 32'(bus.out_valid), 32'd0);
          else begin
            mon_e = exp_out.pop_front();
            check("out_data", bus.out_data, mon_e.data);
            check("out_kind", 32'(bus.out_kind), 32'(mon_e.kind));
            check("out_last", 32'(bus.out_last), 32'(mon_e.last));
          end
          held = 1'b0;
        end else begin
          held = 1'b1;
          prev = '{bus.out_data, bus.out_kind, bus.out_last};
        end
      end
    end
  end

  task automatic start_req(input int row, input int col, input bit s8);
    build_model(row, col, s8);
    out_log.delete();
    rd_log.delete();
    first_valid_cyc = -1;
    first_rd_cyc    = -1;
    @(posedge clk); #1;
    bus.req_mbnumber = {16'(row), 16'(col)};
    bus.req_size8    = s8;
    bus.req_valid    = 1'b1;
    @(posedge clk); #1;
    last_acc         = cyc;
    bus.req_valid    = 1'b0;
    bus.req_mbnumber = 32'hFFFF_FFFF;
    bus.req_size8    = ~s8;
  endtask

  task automatic finish_req(input int stall_idx, input int n_words);
    bit done;
    done = 1'b0;
    stalls_done = 0;
    for (int k = 0; k < 400; k++) begin
      if (bus.req_ready && exp_out.size() == 0) begin
        done = 1'b1;
        break;
      end
      if (stall_idx >= 0 && stalls_done < 5 && bus.out_valid && out_log.size() == stall_idx) begin
        bus.out_ready = 1'b0;
        stalls_done++;
      end else bus.out_ready = 1'b1;
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    check("req_timeout", 32'(done), 32'd1);
    check("word_count", 32'(out_log.size()), 32'(n_words));
    check("reads_left", 32'(exp_rd.size()), 32'd0);
  endtask

  task automatic run_req(input int row, input int col, input bit s8, input int stall_idx, input int n_words);
    start_req(row, col, s8);
    finish_req(stall_idx, n_words);
  endtask

  task automatic reject_req(input int row, input int col, input bit s8);
    exp_out.delete();
    exp_rd.delete();
    out_log.delete();
    rd_log.delete();
    @(posedge clk); #1;
    bus.req_mbnumber = {16'(row), 16'(col)};
    bus.req_size8    = s8;
    bus.req_valid    = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("rej_err", 32'(bus.err), 32'd1);
    check("rej_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    check("rej_err_pulse", 32'(bus.err), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rej_reads", 32'(rd_log.size()), 32'd0);
    check("rej_words", 32'(out_log.size()), 32'd0);
    check("rej_ready_after", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_mbnumber = 32'd0;
    bus.req_size8    = 1'b0;
    bus.out_ready    = 1'b1;
    reset            = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_out_kind", 32'(bus.out_kind), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    reset = 1'b0;

    // 4x4 interior block at row 4, col 8.
    run_req(4, 8, 1'b0, -1, 7);
    check("t1_first_rd", 32'(first_rd_cyc - last_acc), 32'd0);
    check("t1_first_valid", 32'(first_valid_cyc - last_acc), 32'd2);
    check("t1_rd_count", 32'(rd_log.size()), 32'd10);
    for (int k = 0; k < 10 && k < rd_log.size(); k++) check("t1_rd_lit", 32'(rd_log[k]), 32'(t1_rd[k]));
    for (int k = 0; k < 7 && k < out_log.size(); k++) begin
      check("t1_kind_lit", 32'(out_log[k].kind), 32'(t1_kind[k]));
      check("t1_last_lit", 32'(out_log[k].last), 32'(k == 6));
    end

    // 4x4 at the frame origin: all neighbours constant.
    run_req(0, 0, 1'b0, -1, 7);
    if (out_log.size() >= 3) begin
      check("t2_top_lit", out_log[0].data, 32'h8080_8080);
      check("t2_tl_lit", out_log[1].data, 32'h0000_0080);
      check("t2_left_lit", out_log[2].data, 32'h8080_8080);
    end else check("t2_words", 32'(out_log.size()), 32'd7);
    check("t2_rd_count", 32'(rd_log.size()), 32'd4);
    for (int k = 0; k < 4 && k < rd_log.size(); k++) check("t2_rd_lit", 32'(rd_log[k]), 32'(t2_rd[k]));

    // 8x8 on the top edge at col 16.
    run_req(0, 16, 1'b1, -1, 21);
    check("t3_rd_count", 32'(rd_log.size()), 32'd24);
    for (int k = 0; k < 8 && k < rd_log.size(); k++) check("t3_left_rd_lit", 32'(rd_log[k]), 32'(t3_rd[k]));
    if (out_log.size() >= 3) begin
      check("t3_top0_lit", out_log[0].data, 32'h8080_8080);
      check("t3_top1_lit", out_log[1].data, 32'h8080_8080);
      check("t3_tl_lit", out_log[2].data, 32'h0000_0080);
    end

    // Consumer stalls for 5 cycles on the second block word.
    run_req(8, 12, 1'b0, 4, 7);
    check("t4_stall_cycles", 32'(stalls_done), 32'd5);

    // Rejections: misaligned column, and an 8x8 running off the bottom.
    reject_req(4, 6, 1'b0);
    reject_req(716, 8, 1'b1);

    // Last legal 4x4 in the frame.
    run_req(716, 1276, 1'b0, -1, 7);

    // Reset in the middle of the left-neighbour gather.
    start_req(8, 8, 1'b1);
    for (int k = 0; k < 100; k++) begin
      if (rd_log.size() >= 5) break;
      @(posedge clk); #1;
    end
    check("t6_reached_left", 32'(rd_log.size() >= 5), 32'd1);
    reset = 1'b1;
    exp_out.delete();
    exp_rd.delete();
    @(posedge clk); #1;
    check("t6_out_valid", 32'(bus.out_valid), 32'd0);
    check("t6_mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
    check("t6_req_ready", 32'(bus.req_ready), 32'd1);
    reset = 1'b0;
    rd_log.delete();
    out_log.delete();
    repeat (3) @(posedge clk);
    #1;
    check("t6_quiet_reads", 32'(rd_log.size()), 32'd0);
    check("t6_quiet_words", 32'(out_log.size()), 32'd0);
    run_req(12, 20, 1'b0, -1, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
